// File: rtl/bus_ram_pkg.sv
// Shared types and helpers for the burst-capable bus RAM.
package bus_ram_pkg;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_READ, S_WRITE} state_t;

  // Number of bus beats needed to carry one address, never less than one.
  function automatic int addr_beats(input int aw, input int dw);
    int b;
    b = (aw + dw - 1) / dw;
    return (b < 1) ? 1 : b;
  endfunction

endpackage

// File: rtl/tri_buf.sv
// Tristate pad buffer: drives the pad when oe is set and always senses it.
module tri_buf #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic             oe,
  inout  wire  [WIDTH-1:0] pad,
  output logic [WIDTH-1:0] sense
);

  assign pad   = oe ? data : {WIDTH{1'bz}};
  assign sense = pad;

endmodule

// File: rtl/bus_ram_burst.sv
// DEPTH-word RAM on a shared tristate bus with multi-beat addressing,
// auto-incrementing bursts and a busy flag.
module bus_ram_burst
  import bus_ram_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 8,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              rw,
  input  logic              burst,
  inout  wire  [DATA_W-1:0] bus,
  output logic              busy
);

  localparam int DEPTH      = 2 ** ADDR_W;
  localparam int ADDR_BEATS = addr_beats(ADDR_W, DATA_W);
  localparam int BEAT_W     = $clog2(ADDR_BEATS) + 1;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   addr;
  logic [BEAT_W-1:0]   beat_cnt, cap_idx;
  logic                rw_l, burst_l;
  logic                bus_oe;
  logic [DATA_W-1:0]   bus_data, bus_in;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic cap, latch, rd_en, we, inc;

  tri_buf #(.WIDTH(DATA_W)) u_pad (
    .data  (bus_data),
    .oe    (bus_oe),
    .pad   (bus),
    .sense (bus_in)
  );

  assign busy    = (state != S_IDLE);
  assign cap_idx = (state == S_IDLE) ? '0 : beat_cnt;

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    cap     = 1'b0;
    latch   = 1'b0;
    rd_en   = 1'b0;
    we      = 1'b0;
    inc     = 1'b0;
    case (state)
      S_IDLE: if (enable) begin
        cap   = 1'b1;
        latch = 1'b1;
        if (ADDR_BEATS > 1) state_n = S_ADDR;
        else                state_n = rw ? S_WRITE : S_READ;
      end
      S_ADDR: begin
        if (!enable) state_n = S_IDLE;
        else begin
          cap = 1'b1;
          if (int'(beat_cnt) == ADDR_BEATS - 1) state_n = rw_l ? S_WRITE : S_READ;
        end
      end
      S_READ: begin
        if (enable && !rw) begin
          rd_en = 1'b1;
          if (burst_l) inc = 1'b1;
          else         state_n = S_IDLE;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_WRITE: if (enable) begin
        if (rw) begin
          we = 1'b1;
          if (burst_l) inc = 1'b1;
          else         state_n = S_IDLE;
        end else begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr     <= '0;
      beat_cnt <= '0;
      rw_l     <= 1'b0;
      burst_l  <= 1'b0;
      bus_oe   <= 1'b0;
      bus_data <= '0;
    end else begin
      // Output enable only follows a read-data cycle, so address beats never collide.
      bus_oe <= rd_en;
      if (rd_en) bus_data <= mem[addr];
      if (latch) begin
        rw_l    <= rw;
        burst_l <= burst;
      end
      if (cap) begin
        // Bits of the last beat that fall above ADDR_W are dropped here.
        for (int i = 0; i < ADDR_W; i++)
          if (i / DATA_W == int'(cap_idx)) addr[i] <= bus_in[i % DATA_W];
        beat_cnt <= cap_idx + BEAT_W'(1);
      end
      if (inc) addr <= addr + ADDR_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      if (CLEAR_ON_RESET)
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[addr] <= bus_in;
    end
  end

endmodule
